// File: rtl/fn_sw_pkg.sv
// Shared definitions for the fn_sw select/logic cell checker.
// FSM encodings, vector constants and the golden reference function.
package fn_sw_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_CHECK  = CHECK,
    ST_DONE   = DONE
  } fsm_t;

  localparam int         VEC_W    = 3;
  localparam logic [2:0] VEC_LAST = 3'd7;

  function automatic logic fn_sw_exp(
    input logic sel,
    input logic a,
    input logic b
  );
    return sel ? (a & b) : (a ^ b);
  endfunction

endpackage

// File: rtl/fn_sw_checker_golden.sv
// Combinational golden model of the fn_sw cell.
// Ports: a, b, sel (in) -> exp (out) = sel ? a&b : a^b.
module fn_sw_golden
  import fn_sw_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic exp
);

  assign exp = fn_sw_exp(sel, a, b);

endmodule

// File: rtl/fn_sw_checker.sv
// Stimulus/response engine sweeping all 8 {sel,a,b} vectors of fn_sw.
// Ports: clk, rst, start, y in; a, b, sel, busy, done, pass,
// err_cnt, fail_valid, fail_vec out.
module fn_sw_checker
  import fn_sw_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             sel,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  fsm_t             r_state;
  logic [VEC_W-1:0] r_vec;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_fv;
  logic [VEC_W-1:0] r_fvec;

  logic w_exp;
  logic w_mis;

  fn_sw_golden u_golden (
    .a   (r_vec[1]),
    .b   (r_vec[0]),
    .sel (r_vec[2]),
    .exp (w_exp)
  );

  assign w_mis = (y != w_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fv    <= 1'b0;
      r_fvec  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_vec   <= '0;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fvec  <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 8'd0) r_state <= ST_CHECK;
          else r_cnt <= r_cnt - 8'd1;
        end
        ST_CHECK: begin
          if (w_mis && r_err != ERR_MAX)
            r_err <= r_err + 1'b1;
          // only the first miss of a sweep is latched
          if (w_mis && !r_fv) begin
            r_fv   <= 1'b1;
            r_fvec <= r_vec;
          end
          if (r_vec == VEC_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !r_fv && !w_mis;
          end else begin
            r_state <= ST_SETTLE;
            r_vec   <= r_vec + 3'd1;
            r_cnt   <= CNT_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel        = r_vec[2];
  assign a          = r_vec[1];
  assign b          = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_valid = r_fv;
  assign fail_vec   = r_fvec;

endmodule
